// File: rtl/reg_file_lanes_if.sv
// Register file bus: write port with per-lane enables, two read ports,
// a debug read port and the clear-sequencer handshake.
interface reg_file_lanes_if #(
    parameter int DATA_W = 32,
    parameter int LANE_W = 16,
    parameter int ADDR_W = 3
);
    localparam int NLANES = DATA_W / LANE_W;

    logic [NLANES-1:0] we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr0;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic [ADDR_W-1:0] dbg_sel;
    logic [DATA_W-1:0] dbg_val;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;

    // Decode / writeback side
    modport master (
        output we, waddr, wdata, raddr0, raddr1, dbg_sel, clr_req,
        input  rdata0, rdata1, dbg_val, clr_busy, clr_done
    );

    // Register file side
    modport slave (
        input  we, waddr, wdata, raddr0, raddr1, dbg_sel, clr_req,
        output rdata0, rdata1, dbg_val, clr_busy, clr_done
    );
endinterface

// File: rtl/reg_file_lanes.sv
// Parametrised register file with lane-granular writes, optional hardwired
// zero register, a debug read port and a one-register-per-cycle clear
// sequencer. All state updates on the falling clock edge so the datapath
// sees written data before the following rising edge.
module reg_file_lanes #(
    parameter int DATA_W   = 32,
    parameter int LANE_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_R0  = 0
) (
    input  logic             clk,
    input  logic             resetn,
    reg_file_lanes_if.slave  bus
);
    localparam int NLANES = DATA_W / LANE_W;

    // Upper bound for a readable/writable address, one bit wider than the
    // address so NUM_REGS == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   REGS_LIMIT = (ADDR_W + 1)'(NUM_REGS);
    // Pointer value of the last register visited by the clear sequence;
    // leaving CLEAR here keeps the pointer from ever wrapping.
    localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] reg_q [NUM_REGS];

    // One bit per (register, lane): that lane is written at this edge
    logic [NUM_REGS*NLANES-1:0] lane_wr;
    // One bit per register: the clear sequencer zeroes it at this edge
    logic [NUM_REGS-1:0]        clr_hit;

    logic [DATA_W-1:0] rdata0_c;
    logic [DATA_W-1:0] rdata1_c;
    logic [DATA_W-1:0] dbg_val_c;

    // An address returns stored data only if it names a real register and
    // is not the hardwired-zero register.
    function automatic logic addr_readable(input logic [ADDR_W-1:0] a);
        logic ok;
        ok = ({1'b0, a} < REGS_LIMIT);
        if ((ZERO_R0 != 0) && (a == '0)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // ------------------------------------------------------------------
    // Per-register write and clear decode
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            // Register 0 never accepts writes when it is hardwired to zero
            localparam bit WRITABLE = !((ZERO_R0 != 0) && (gi == 0));

            assign clr_hit[gi] = (state_q == ST_CLEAR) && (ptr_q == ADDR_W'(gi));

            for (genvar li = 0; li < NLANES; li++) begin : g_lane
                // Writes land only while idle; matching waddr to an existing
                // register index also drops out-of-range addresses.
                assign lane_wr[gi*NLANES + li] = WRITABLE
                                               && (state_q == ST_IDLE)
                                               && bus.we[li]
                                               && (bus.waddr == ADDR_W'(gi));
            end
        end
    endgenerate

    // Register storage: reset clears everything, the sequencer clears one
    // register per edge, otherwise enabled lanes take the write data.
    always_ff @(negedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (clr_hit[i]) begin
                    reg_q[i] <= '0;
                end else begin
                    for (int l = 0; l < NLANES; l++) begin
                        if (lane_wr[i*NLANES + l]) begin
                            reg_q[i][l*LANE_W +: LANE_W] <= bus.wdata[l*LANE_W +: LANE_W];
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------

    // Sequencer state register
    always_ff @(negedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    // Sequencer next state: walk the pointer from 0 to the last register,
    // pulse done on the edge that leaves CLEAR; requests during CLEAR are
    // dropped rather than queued.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.clr_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Combinational read ports (never blocked by the clear sequence)
    // ------------------------------------------------------------------

    // Read port 0
    always_comb begin
        rdata0_c = '0;
        if (addr_readable(bus.raddr0)) begin
            rdata0_c = reg_q[bus.raddr0];
        end
    end

    // Read port 1
    always_comb begin
        rdata1_c = '0;
        if (addr_readable(bus.raddr1)) begin
            rdata1_c = reg_q[bus.raddr1];
        end
    end

    // Debug read port
    always_comb begin
        dbg_val_c = '0;
        if (addr_readable(bus.dbg_sel)) begin
            dbg_val_c = reg_q[bus.dbg_sel];
        end
    end

    assign bus.rdata0   = rdata0_c;
    assign bus.rdata1   = rdata1_c;
    assign bus.dbg_val  = dbg_val_c;
    assign bus.clr_busy = (state_q == ST_CLEAR);
    assign bus.clr_done = done_q;

endmodule
